sprite_draw_datapath: RTL

SPRITE_DRAW_DATAPATH -- requirements
Module: sprite_draw_datapath

---
 rtl/sprite_draw_datapath_pkg.sv | 41 ++++
 rtl/sprite_scan_counter.sv | 28 ++
 rtl/sprite_draw_datapath.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_draw_datapath_pkg.sv
// Shared game definitions: command codes, screen geometry, palette and engine states.
// Used by the movement FSM and the sprite draw datapath.
package sprite_draw_datapath_pkg;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;
    localparam int unsigned SPR   = 8;

    typedef enum logic [3:0] {
        CmdNop   = 4'b0000,
        CmdClear = 4'b0001,
        CmdRight = 4'b0010,
        CmdLeft  = 4'b0011,
        CmdDraw  = 4'b0101,
        CmdDown  = 4'b0110,
        CmdUp    = 4'b0111
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } eng_state_e;

    localparam logic [2:0] COL_SKY   = 3'b011;
    localparam logic [2:0] COL_BIRD  = 3'b110;
    localparam logic [2:0] COL_CROSS = 3'b111;

    // Saturating step; 9-bit operands keep the compare free of wrap-around.
    function automatic logic [8:0] sat_step(input logic [8:0] pos, input logic inc,
                                            input logic [8:0] step, input logic [8:0] max);
        logic [8:0] res;
        if (inc) begin
            res = (pos + step > max) ? max : pos + step;
        end else begin
            res = (pos < step) ? 9'd0 : pos - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// 64-pixel row-major scan counter for an 8x8 sprite, with a last-pixel flag.
// Counts while enabled and returns to zero otherwise.
module sprite_scan_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [5:0] cnt,
    output logic       last
);

    logic [5:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = en ? cnt_q + 6'd1 : 6'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 6'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == 6'd63);

endmodule

// File: rtl/sprite_draw_datapath.sv
// Sprite engine: moves crosshair/bird in IDLE, scans an 8x8 clear/draw into the VGA plotter,
// and flags when the crosshair centre sits inside the bird box.
module sprite_draw_datapath #(
    parameter int unsigned SCR_W = sprite_draw_datapath_pkg::SCR_W,
    parameter int unsigned SCR_H = sprite_draw_datapath_pkg::SCR_H,
    parameter int unsigned SPR   = sprite_draw_datapath_pkg::SPR,
    parameter int unsigned STEP  = 2,
    parameter int unsigned P_X0  = 76,
    parameter int unsigned P_Y0  = 56,
    parameter int unsigned B_X0  = 0,
    parameter int unsigned B_Y0  = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cmd,
    input  logic       sel_bird,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       done_drawing,
    output logic       hit,
    output logic [7:0] p_x,
    output logic [6:0] p_y,
    output logic [7:0] b_x,
    output logic [6:0] b_y
);
    import sprite_draw_datapath_pkg::*;

    localparam logic [8:0] X_MAX  = 9'(SCR_W - SPR);
    localparam logic [8:0] Y_MAX  = 9'(SCR_H - SPR);
    localparam logic [8:0] STEP_W = 9'(STEP);

    eng_state_e state_q, state_d;
    logic       start, run_en, idle;
    logic       sel_q, draw_q;
    logic [5:0] cnt;
    logic       last;

    logic [7:0] p_x_q, p_x_d, b_x_q, b_x_d, vga_x_q, vga_x_d;
    logic [6:0] p_y_q, p_y_d, b_y_q, b_y_d, vga_y_q, vga_y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, done_q, done_d, hit_q, hit_d;

    sprite_scan_counter u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run_en),
        .cnt     (cnt),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd == CmdClear || cmd == CmdDraw) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idle   = (state_q == StIdle);
        run_en = (state_q == StRun);
        start  = idle && (state_d == StRun);
    end

    // Outputs are registered from the pixel that the next cycle presents, so plot lines up with RUN.
    logic       pix_on, pix_sel, pix_draw;
    logic [5:0] pix_idx;
    logic [2:0] col, row;
    logic [7:0] sx;
    logic [6:0] sy;

    always_comb begin
        pix_on   = start || (run_en && !last);
        pix_sel  = start ? sel_bird : sel_q;
        pix_draw = start ? (cmd == CmdDraw) : draw_q;
        pix_idx  = start ? 6'd0 : cnt + 6'd1;
        col      = pix_idx[2:0];
        row      = pix_idx[5:3];
        sx       = pix_sel ? b_x_q : p_x_q;
        sy       = pix_sel ? b_y_q : p_y_q;
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = run_en && last;
        if (pix_on) begin
            vga_x_d = sx + {5'd0, col};
            vga_y_d = sy + {4'd0, row};
            if (!pix_draw) begin
                colour_d = COL_SKY;
                plot_d   = 1'b1;
            end else if (pix_sel) begin
                colour_d = COL_BIRD;
                plot_d   = 1'b1;
            end else begin
                colour_d = COL_CROSS;
                plot_d   = (row == 3'd3) || (col == 3'd3);
            end
        end
    end

    logic [8:0] tx, ty, tx_n, ty_n, cx, cy;
    logic       mv;

    always_comb begin
        tx    = sel_bird ? {1'b0, b_x_q} : {1'b0, p_x_q};
        ty    = sel_bird ? {2'b0, b_y_q} : {2'b0, p_y_q};
        tx_n  = tx;
        ty_n  = ty;
        mv    = 1'b1;
        case (cmd)
            CmdRight: tx_n = sat_step(tx, 1'b1, STEP_W, X_MAX);
            CmdLeft:  tx_n = sat_step(tx, 1'b0, STEP_W, X_MAX);
            CmdDown:  ty_n = sat_step(ty, 1'b1, STEP_W, Y_MAX);
            CmdUp:    ty_n = sat_step(ty, 1'b0, STEP_W, Y_MAX);
            default:  mv = 1'b0;
        endcase
        p_x_d = p_x_q;
        p_y_d = p_y_q;
        b_x_d = b_x_q;
        b_y_d = b_y_q;
        if (idle && mv) begin
            if (sel_bird) begin
                b_x_d = tx_n[7:0];
                b_y_d = ty_n[6:0];
            end else begin
                p_x_d = tx_n[7:0];
                p_y_d = ty_n[6:0];
            end
        end
        cx    = {1'b0, p_x_q} + 9'd3;
        cy    = {2'b0, p_y_q} + 9'd3;
        hit_d = (cx >= {1'b0, b_x_q}) && (cx <= {1'b0, b_x_q} + 9'(SPR - 1)) &&
                (cy >= {2'b0, b_y_q}) && (cy <= {2'b0, b_y_q} + 9'(SPR - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= 1'b0;
            draw_q   <= 1'b0;
            vga_x_q  <= 8'd0;
            vga_y_q  <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            p_x_q    <= 8'(P_X0);
            p_y_q    <= 7'(P_Y0);
            b_x_q    <= 8'(B_X0);
            b_y_q    <= 7'(B_Y0);
        end else begin
            if (start) begin
                sel_q  <= sel_bird;
                draw_q <= (cmd == CmdDraw);
            end
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            p_x_q    <= p_x_d;
            p_y_q    <= p_y_d;
            b_x_q    <= b_x_d;
            b_y_q    <= b_y_d;
        end
    end

    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_colour   = colour_q;
    assign plot         = plot_q;
    assign done_drawing = done_q;
    assign hit          = hit_q;
    assign p_x          = p_x_q;
    assign p_y          = p_y_q;
    assign b_x          = b_x_q;
    assign b_y          = b_y_q;

endmodule
